// File: rtl/lc3_fetch_pkg.sv
// Shared types and defaults for the LC3 prefetching fetch stage.
package lc3_fetch_pkg;

   localparam int          LC3_AW       = 16;
   localparam int          LC3_DW       = 16;
   localparam logic [15:0] LC3_RESET_PC = 16'h3000;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/lc3_fetch_prefetch_queue.sv
// Synchronous FIFO with occupancy count and a single-cycle clear; used both for
// fetched instructions and for the per-request address tracker.
module fetch_queue #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_clear,
   input  logic                         i_push,
   input  logic                         i_pop,
   input  logic [W-1:0]                 i_wdata,
   output logic [W-1:0]                 o_rdata,
   output logic                         o_full,
   output logic                         o_empty,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_count = r_count;
   assign o_rdata = r_mem[r_rd_ptr];

   // A push into a full queue is only accepted when the head leaves the same cycle.
   assign w_pop  = i_pop & ~o_empty;
   assign w_push = i_push & (~o_full | w_pop);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push && !i_clear) r_mem[r_wr_ptr] <= i_wdata;
   end

endmodule

// File: rtl/lc3_fetch_prefetch.sv
// LC3 fetch stage with an in-order prefetch queue and branch flush.
// Optional FETCH_BYPASS_EN: an empty queue forwards a response straight to decode.
module lc3_fetch_prefetch
   import lc3_fetch_pkg::*;
#(
   parameter int            AW       = LC3_AW,
   parameter int            DW       = LC3_DW,
   parameter int            DEPTH    = 4,
   parameter logic [AW-1:0] RESET_PC = AW'(LC3_RESET_PC)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          enable_fetch,
   input  logic          enable_updatepc,
   input  logic          br_taken,
   input  logic [AW-1:0] taddr,
   output logic [AW-1:0] pc,
   output logic [AW-1:0] npc_out,
   output logic          instrmem_rd,
   input  logic          imem_rvalid,
   input  logic [DW-1:0] imem_rdata,
   output logic          instr_valid,
   input  logic          instr_ready,
   output logic [DW-1:0] instr_out,
   output logic [AW-1:0] instr_npc
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = CW + 2;

   fetch_state_e     r_state;
   fetch_state_e     w_state_next;
   logic [AW-1:0]    r_pc;
   logic [CW-1:0]    r_outstanding;
   logic [CW-1:0]    r_drop_cnt;
   logic [CW-1:0]    w_outstanding_next;
   logic [CW-1:0]    w_drop_next;
   logic [CW-1:0]    w_q_count;
   logic [CW-1:0]    w_trk_count;
   logic [SW-1:0]    w_credit_used;
   logic [AW-1:0]    w_pc_inc;
   logic [AW-1:0]    w_trk_rdata;
   logic [DW+AW-1:0] w_q_rdata;
   logic             w_q_full;
   logic             w_q_empty;
   logic             w_trk_full;
   logic             w_trk_empty;
   logic             w_issue;
   logic             w_accept;
   logic             w_drop_resp;
   logic             w_bypass;
   logic             w_push;
   logic             w_pop;
   logic             w_unused;

   assign w_pc_inc = r_pc + AW'(1);
   assign pc       = r_pc;
   assign npc_out  = w_pc_inc;

   // Queued, in-flight and to-be-dropped responses all hold a credit.
   assign w_credit_used = SW'(w_q_count) + SW'(r_outstanding) + SW'(r_drop_cnt);
   assign w_issue       = enable_fetch & enable_updatepc & ~br_taken & (r_state != S_IDLE)
                        & (w_credit_used < SW'(DEPTH));
   assign instrmem_rd   = w_issue;

   assign w_drop_resp = imem_rvalid & (r_drop_cnt != '0);
   assign w_accept    = imem_rvalid & (r_drop_cnt == '0) & ~br_taken;

`ifdef FETCH_BYPASS_EN
   assign w_bypass = w_accept & w_q_empty & instr_ready;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_push      = w_accept & ~w_bypass;
   assign w_pop       = ~w_q_empty & instr_ready & ~br_taken;
   assign instr_valid = (~w_q_empty | w_bypass) & ~br_taken;
   assign instr_out   = w_bypass ? imem_rdata  : w_q_rdata[DW+AW-1:AW];
   assign instr_npc   = w_bypass ? w_trk_rdata : w_q_rdata[AW-1:0];

   always_comb begin
      w_outstanding_next = r_outstanding;
      w_drop_next        = r_drop_cnt;
      if (br_taken) begin
         // Everything still in flight becomes wrong-path; this cycle's response is already gone.
         w_outstanding_next = '0;
         w_drop_next        = r_outstanding + r_drop_cnt - CW'(imem_rvalid);
      end else begin
         w_outstanding_next = r_outstanding + CW'(w_issue) - CW'(w_accept);
         if (w_drop_resp) w_drop_next = r_drop_cnt - CW'(1);
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  w_state_next = S_RUN;
         S_RUN:   if (br_taken && (w_drop_next != '0)) w_state_next = S_FLUSH;
         S_FLUSH: if (w_drop_next == '0) w_state_next = S_RUN;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_pc          <= RESET_PC;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
      end else begin
         r_state       <= w_state_next;
         r_outstanding <= w_outstanding_next;
         r_drop_cnt    <= w_drop_next;
         if (br_taken)     r_pc <= taddr;
         else if (w_issue) r_pc <= w_pc_inc;
      end
   end

   fetch_queue #(.W(DW + AW), .DEPTH(DEPTH)) u_queue (
      .i_clk   (clock),
      .i_rst_n (reset),
      .i_clear (br_taken),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata ({imem_rdata, w_trk_rdata}),
      .o_rdata (w_q_rdata),
      .o_full  (w_q_full),
      .o_empty (w_q_empty),
      .o_count (w_q_count)
   );

   // Holds address+1 of each correct-path request until its response is accepted.
   fetch_queue #(.W(AW), .DEPTH(DEPTH)) u_track (
      .i_clk   (clock),
      .i_rst_n (reset),
      .i_clear (br_taken),
      .i_push  (w_issue),
      .i_pop   (w_accept),
      .i_wdata (w_pc_inc),
      .o_rdata (w_trk_rdata),
      .o_full  (w_trk_full),
      .o_empty (w_trk_empty),
      .o_count (w_trk_count)
   );

   assign w_unused = ^{w_q_full, w_trk_full, w_trk_empty, w_trk_count};

endmodule

// File: tb/tb_lc3_fetch_prefetch.sv
// Scoreboard bench for lc3_fetch_prefetch: a latency-programmable memory model
// feeds the DUT, and every correct-path issue queues its expected delivery.
`timescale 1ns/1ps
module tb_lc3_fetch_prefetch;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        enable_fetch = 1'b0;
   logic        enable_updatepc = 1'b1;
   logic        br_taken = 1'b0;
   logic [15:0] taddr = 16'h0000;
   logic [15:0] pc;
   logic [15:0] npc_out;
   logic        instrmem_rd;
   logic        imem_rvalid = 1'b0;
   logic [15:0] imem_rdata = 16'h0000;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [15:0] instr_out;
   logic [15:0] instr_npc;

`ifdef FETCH_BYPASS_EN
   localparam int FIRST_DELIV = 2;
`else
   localparam int FIRST_DELIV = 3;
`endif

   lc3_fetch_prefetch #(.AW(16), .DW(16), .DEPTH(4), .RESET_PC(16'h3000)) dut (
      .clock           (clock),
      .reset           (reset),
      .enable_fetch    (enable_fetch),
      .enable_updatepc (enable_updatepc),
      .br_taken        (br_taken),
      .taddr           (taddr),
      .pc              (pc),
      .npc_out         (npc_out),
      .instrmem_rd     (instrmem_rd),
      .imem_rvalid     (imem_rvalid),
      .imem_rdata      (imem_rdata),
      .instr_valid     (instr_valid),
      .instr_ready     (instr_ready),
      .instr_out       (instr_out),
      .instr_npc       (instr_npc)
   );

   always #5 clock = ~clock;

   typedef struct { logic [15:0] addr; int due; } mreq_t;
   typedef struct { logic [15:0] data; logic [15:0] npc; } exp_t;

   mreq_t       mem_q[$];
   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          n_iss = 0;
   int          n_deliv = 0;
   int          cyc = 0;
   int          lat = 1;
   int          last_cyc = 0;
   int          base;
   logic [15:0] last_npc = 16'h0000;
   logic [15:0] model_pc = 16'h3000;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h want=%h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic mem_drive();
      if (reset && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_q[0].addr ^ 16'h5A5A;
         mem_q.delete(0);
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = 16'hDEAD;
      end
   endtask

   task automatic observe();
      exp_t e;
      if (instrmem_rd) mem_q.push_back('{addr: pc, due: cyc + lat});
      if (br_taken) begin
         check_eq("br_no_rd", instrmem_rd, 0);
         check_eq("br_no_valid", instr_valid, 0);
         exp_q.delete();
         model_pc = taddr;
      end else if (instrmem_rd) begin
         check_eq("issue_addr", pc, model_pc);
         n_iss++;
         exp_q.push_back('{data: model_pc ^ 16'h5A5A, npc: model_pc + 16'd1});
         model_pc = model_pc + 16'd1;
      end
      if (!enable_updatepc) check_eq("freeze_rd", instrmem_rd, 0);
      if (instr_valid && !instr_ready && exp_q.size() > 0)
         check_eq("head_npc", instr_npc, exp_q[0].npc);
      if (instr_valid && instr_ready) begin
         if (exp_q.size() == 0) begin
            check_eq("spurious_valid", instr_valid, 0);
         end else begin
            e = exp_q.pop_front();
            check_eq("instr_out", instr_out, e.data);
            check_eq("instr_npc", instr_npc, e.npc);
            n_deliv++;
            last_npc = instr_npc;
            last_cyc = cyc;
         end
      end
   endtask

   task automatic cycle();
      mem_drive();
      #1;
      observe();
      @(negedge clock);
      cyc++;
   endtask

   task automatic run_until(input int target, input int bound, input string tag);
      int i = 0;
      while (n_deliv < target && i < bound) begin
         cycle();
         i++;
      end
      if (n_deliv < target) check_eq(tag, n_deliv, target);
   endtask

   task automatic do_reset();
      reset       = 1'b0;
      br_taken    = 1'b0;
      imem_rvalid = 1'b0;
      mem_q.delete();
      exp_q.delete();
      model_pc    = 16'h3000;
      #1;
      check_eq("rst_pc", pc, 16'h3000);
      check_eq("rst_npc_out", npc_out, 16'h3001);
      check_eq("rst_rd", instrmem_rd, 0);
      check_eq("rst_valid", instr_valid, 0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      cyc   = 0;
   endtask

   // Two reads queued and two in flight with no response in the branch cycle.
   task automatic flush_setup();
      lat = 3; instr_ready = 1'b0; enable_fetch = 1'b1;
      do_reset();
      base = n_iss;
      cycle(); cycle(); cycle();
      enable_fetch = 1'b0;
      cycle(); cycle();
      enable_fetch = 1'b1;
      cycle(); cycle();
      check_eq("flush_setup_issues", n_iss - base, 4);
      br_taken = 1'b1; taddr = 16'h4000;
      cycle();
      br_taken = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      @(negedge clock);

      // Streaming at latency 1, first-delivery latency, and PC freeze.
      lat = 1; instr_ready = 1'b1; enable_fetch = 1'b1; enable_updatepc = 1'b1;
      do_reset();
      check_eq("t1_idle_rd", instrmem_rd, 0);
      cycle();
      check_eq("t1_first_rd", instrmem_rd, 1);
      check_eq("t1_first_pc", pc, 16'h3000);
      base = n_deliv;
      run_until(base + 1, 10, "t1_timeout");
      check_eq("t1_first_cycle", last_cyc, FIRST_DELIV);
      check_eq("t1_first_npc", last_npc, 16'h3001);
      base = n_deliv;
      repeat (8) cycle();
      check_eq("t1_rate", n_deliv - base, 8);
      enable_updatepc = 1'b0;
      repeat (3) cycle();
      check_eq("t1_freeze_pc", pc, model_pc);
      enable_updatepc = 1'b1;
      repeat (4) cycle();

      // Credit limit with decode stalled at latency 3.
      lat = 3; instr_ready = 1'b0;
      do_reset();
      base = n_iss;
      repeat (12) cycle();
      check_eq("t2_issue_cnt", n_iss - base, 4);
      check_eq("t2_rd_blocked", instrmem_rd, 0);
      instr_ready = 1'b1;
      base = n_deliv;
      run_until(base + 1, 10, "t2_timeout_first");
      check_eq("t2_first_npc", last_npc, 16'h3001);
      run_until(base + 4, 10, "t2_timeout_fourth");
      check_eq("t2_fourth_npc", last_npc, 16'h3004);

      // Branch with queued and in-flight wrong-path reads.
      flush_setup();
      check_eq("t3_q_flushed", instr_valid, 0);
      check_eq("t3_pc", pc, 16'h4000);
      check_eq("t3_npc_out", npc_out, 16'h4001);
      instr_ready = 1'b1;
      base = n_deliv;
      run_until(base + 1, 20, "t3_timeout");
      check_eq("t3_first_npc", last_npc, 16'h4001);
      repeat (4) cycle();

      // PC wrap at the top of the address space.
      lat = 1; instr_ready = 1'b1; enable_fetch = 1'b1;
      do_reset();
      base = n_deliv;
      cycle();
      br_taken = 1'b1; taddr = 16'hFFFF;
      cycle();
      br_taken = 1'b0;
      check_eq("t4_pc_ffff", pc, 16'hFFFF);
      cycle();
      enable_fetch = 1'b0;
      check_eq("t4_pc_wrap", pc, 16'h0000);
      check_eq("t4_npc_out_wrap", npc_out, 16'h0001);
      run_until(base + 1, 10, "t4_timeout");
      check_eq("t4_instr_npc", last_npc, 16'h0000);
      repeat (3) cycle();
      check_eq("t4_single", n_deliv - base, 1);

      // Asynchronous reset while drops are still pending.
      flush_setup();
      #2;
      do_reset();
      lat = 2; instr_ready = 1'b1; enable_fetch = 1'b1;
      base = n_deliv;
      run_until(base + 1, 20, "t5_timeout");
      check_eq("t5_first_npc", last_npc, 16'h3001);
      repeat (6) cycle();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
